// File: rtl/alu_pkg.sv
// Shared ALU opcodes and controller state encodings.
// Used by the alu datapath and by alu_share_ctrl.
package alu_pkg;

    localparam int ALU_ADD = 1;
    localparam int ALU_SUB = 2;
    localparam int ALU_OR  = 3;
    localparam int ALU_AND = 4;
    localparam int ALU_XOR = 5;
    localparam int ALU_NOT = 6;
    localparam int ALU_GT  = 7;
    localparam int ALU_EQ  = 8;

    localparam int ALU_OP_MAX = ALU_EQ;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } share_state_e;

    // Opcodes outside 1..ALU_OP_MAX are rejected.
    function automatic logic alu_op_err(
        input int unsigned op
    );
        return (op == 0) || (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; unknown opcodes produce zero.
// Add/sub wrap, compares return a zero-extended bit.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 4
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    y
);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(ALU_ADD);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(ALU_SUB);
    localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(ALU_OR);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(ALU_AND);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(ALU_XOR);
    localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(ALU_NOT);
    localparam logic [OP_WIDTH-1:0] OP_GT  = OP_WIDTH'(ALU_GT);
    localparam logic [OP_WIDTH-1:0] OP_EQ  = OP_WIDTH'(ALU_EQ);

    // Opcode decode into the selected result.
    always_comb begin
        y = '0;
        unique case (1'b1)
            (op == OP_ADD): y = a + b;
            (op == OP_SUB): y = a - b;
            (op == OP_OR):  y = a | b;
            (op == OP_AND): y = a & b;
            (op == OP_XOR): y = a ^ b;
            (op == OP_NOT): y = ~a;
            (op == OP_GT):  y = {{(WIDTH-1){1'b0}}, (a > b)};
            (op == OP_EQ):  y = {{(WIDTH-1){1'b0}}, (a == b)};
            default:        y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches ptr, ptr+1, ... wrapping at N_REQ.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);

    int cand;

    // First requester at or after ptr wins; wrap by compare, not truncation.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && (i == cand) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = ID_W'(i);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between N_REQ requesters.
// Round-robin grant, latched operands, held response.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int OP_WIDTH = 4,
    parameter  int N_REQ    = 2,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*OP_WIDTH-1:0] req_op,
    input  logic [N_REQ*WIDTH-1:0]    req_a,
    input  logic [N_REQ*WIDTH-1:0]    req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    share_state_e state;

    logic [ID_W-1:0]     rr_ptr;
    logic [OP_WIDTH-1:0] lat_op;
    logic [WIDTH-1:0]    lat_a;
    logic [WIDTH-1:0]    lat_b;
    logic [ID_W-1:0]     lat_id;

    logic [N_REQ-1:0]    grant_oh;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;

    logic [OP_WIDTH-1:0] sel_op;
    logic [WIDTH-1:0]    sel_a;
    logic [WIDTH-1:0]    sel_b;

    logic [WIDTH-1:0]    alu_y;
    logic                lat_err;
    logic [ID_W-1:0]     next_ptr;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant_oh),
        .grant_idx(grant_idx),
        .grant_any(grant_any)
    );

    alu #(
        .WIDTH   (WIDTH),
        .OP_WIDTH(OP_WIDTH)
    ) u_alu (
        .op(lat_op),
        .a (lat_a),
        .b (lat_b),
        .y (alu_y)
    );

    // Payload of the granted requester, chosen by the one-hot grant.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_op = req_op[i*OP_WIDTH +: OP_WIDTH];
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (rst_n && (state == ST_IDLE)) ? grant_oh : '0;
    assign busy      = (state != ST_IDLE);
    assign lat_err   = alu_op_err(32'(lat_op));

    // Pointer moves past the served requester; wrap by explicit compare.
    assign next_ptr = (lat_id == ID_W'(N_REQ - 1)) ? '0 : lat_id + 1'b1;

    // Grant / evaluate / respond sequence with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        lat_op <= sel_op;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_id <= grant_idx;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= lat_err ? '0 : alu_y;
                    rsp_id    <= lat_id;
                    rsp_err   <= lat_err;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
